mdu: RTL

Iterative multiply/divide unit for the MIPS core, executing MULT, MULTU, DIV and DIVU and holding the architectural HI/LO registers.
- Sits beside the ALU in the execute path.
- Consumes the register-file read buses (busa/busb) and the control unit's decoded MDU operation.
- Returns HI/LO to the write-back mux for MFHI/MFLO.
- Asserts busy so ctrl/ifu can stall the PC while an operation is in flight.

---
 rtl/mips_pkg.sv | 16 +
 rtl/mdu_abs.sv | 26 ++
 rtl/mdu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core definitions: MDU op codes and MDU FSM states
package mips_pkg;

  // MDU operation codes, shared with ctrl's decoder.
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_abs.sv
// rtl/mdu_abs.sv - two's-complement magnitude / conditional negation helper
// Ports:
//   x      : value to convert
//   sgn_en : treat x as signed; its MSB then becomes the extracted sign
//   inv    : force an extra negation (used when fixing up result signs)
//   y      : x negated when (sign ^ inv), otherwise x unchanged
//   neg    : extracted sign of x (0 when sgn_en=0)
module mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             sgn_en,
  input  logic             inv,
  output logic [WIDTH-1:0] y,
  output logic             neg
);

  logic flip;

  assign neg  = sgn_en & x[WIDTH-1];
  assign flip = neg ^ inv;
  // The most negative value maps onto itself, which gives the modulo wrap
  // the architecture expects for e.g. 0x8000_0000 / -1.
  assign y    = flip ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-low reset
//   start, op, a, b  : launch request and operands, sampled only while idle
//   hi_we, lo_we     : MTHI/MTLO write enables, honoured only while idle
//   wdata            : MTHI/MTLO data
//   busy             : operation in flight (RUN or COMMIT)
//   done             : one-cycle pulse after HI/LO are committed
//   hi, lo           : architectural HI/LO registers
module mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [2*WIDTH-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig;    // raw rs, returned as HI on divide by zero
  logic               is_div;
  logic               div_zero;
  logic               neg_res;   // product / quotient sign
  logic               neg_rem;   // remainder sign

  logic               commit;
  logic               op_unsigned;
  logic               op_div;

  // The two magnitude units convert a/b at launch and fix up result signs in COMMIT.
  logic [WIDTH-1:0]   abs_a_x, abs_b_x, abs_a_y, abs_b_y;
  logic               abs_sgn_en, abs_a_inv, abs_b_inv;
  logic               sign_a, sign_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_hi_fix;

  assign commit      = (state == COMMIT);
  assign busy        = (state != IDLE);
  assign op_unsigned = (op == MDU_MULTU) || (op == MDU_DIVU);
  assign op_div      = (op == MDU_DIV)   || (op == MDU_DIVU);
  assign cnt_nx      = cnt + CNT_W'(1);

  assign abs_a_x    = commit ? acc[WIDTH-1:0] : a;
  assign abs_b_x    = commit ? acc[2*WIDTH-1:WIDTH] : b;
  assign abs_sgn_en = ~commit & ~op_unsigned;
  assign abs_a_inv  = commit & neg_res;
  assign abs_b_inv  = commit & (is_div ? neg_rem : neg_res);

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
    .x      (abs_a_x),
    .sgn_en (abs_sgn_en),
    .inv    (abs_a_inv),
    .y      (abs_a_y),
    .neg    (sign_a)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
    .x      (abs_b_x),
    .sgn_en (abs_sgn_en),
    .inv    (abs_b_inv),
    .y      (abs_b_y),
    .neg    (sign_b)
  );

  // Radix-2 shift-add: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // Restoring division: shift in the next dividend bit, keep the difference
  // only if it did not borrow (bit WIDTH clear).
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[WIDTH];

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      acc_step = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Negating a double-width product half by half: the high half is negated
  // only when the low half is zero, otherwise the borrow makes it ~hi.
  assign mul_hi_fix = (neg_res && (acc[WIDTH-1:0] != '0)) ? ~acc[2*WIDTH-1:WIDTH] : abs_b_y;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt_nx == CNT_W'(WIDTH)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= commit;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div   <= op_div;
            acc      <= {{WIDTH{1'b0}}, abs_a_y};
            opnd     <= abs_b_y;
            a_orig   <= a;
            div_zero <= (b == '0);
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            cnt      <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt_nx;
        end
        COMMIT: begin
          if (is_div) begin
            if (div_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= abs_b_y;
              lo <= abs_a_y;
            end
          end else begin
            hi <= mul_hi_fix;
            lo <= abs_a_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
